// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI responder backed by an on-chip 64-bit word memory.
// Independent write (AW/W/B) and read (AR/R) FSMs share only the memory array.
module axi_slave_mem #(
    parameter int          DEPTH        = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [63:0] WDATA,
    input  logic        WVALID,
    output logic        WREADY,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [63:0] RDATA,
    output logic        RVALID,
    input  logic        RREADY,
    output logic        addr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] W_IDLE = 1'd0, W_RESP = 1'd1;
    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;
    logic [63:0]   r_mem [DEPTH];
    logic [0:0]    r_wst;
    logic [1:0]    r_rst;
    logic          r_aw_held, r_w_held, r_aw_ok, r_ar_ok, r_werr, r_rerr;
    logic [AW-1:0] r_aw_idx, r_ar_idx;
    logic [63:0]   r_wdata;
    logic [3:0]    r_cnt;
    logic [31:0]   w_aw_off, w_ar_off;
    logic          w_aw_ok, w_ar_ok, w_aw_hs, w_w_hs;
    assign w_aw_off = AWADDR - BASE_ADDR;
    assign w_ar_off = ARADDR - BASE_ADDR;
    assign w_aw_ok  = (AWADDR >= BASE_ADDR) && ((w_aw_off >> 3) < 32'(DEPTH));
    assign w_ar_ok  = (ARADDR >= BASE_ADDR) && ((w_ar_off >> 3) < 32'(DEPTH));
    assign w_aw_hs  = AWVALID && AWREADY;
    assign w_w_hs   = WVALID && WREADY;
    assign addr_err = r_werr | r_rerr;
    // A channel's ready drops as soon as it handshakes and stays low until the B handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wst     <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_ok   <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_werr    <= 1'b0;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
        end else if (r_wst == W_IDLE) begin
            if (r_aw_held && r_w_held) begin
                if (r_aw_ok) r_mem[r_aw_idx] <= r_wdata;
                else r_werr <= 1'b1;
                BVALID <= 1'b1;
                r_wst  <= W_RESP;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_ok   <= w_aw_ok;
                    r_aw_idx  <= w_aw_off[AW+2:3];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= WDATA;
                end
                AWREADY <= !(r_aw_held || w_aw_hs);
                WREADY  <= !(r_w_held || w_w_hs);
            end
        end else if (BREADY) begin
            BVALID    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            AWREADY   <= 1'b1;
            WREADY    <= 1'b1;
            r_wst     <= W_IDLE;
        end
    end
    // Sampling with a nonblocking read returns pre-commit data on a same-edge collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst    <= R_IDLE;
            r_ar_ok  <= 1'b0;
            r_ar_idx <= '0;
            r_cnt    <= '0;
            r_rerr   <= 1'b0;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RDATA    <= '0;
        end else if (r_rst == R_IDLE) begin
            if (ARVALID && ARREADY) begin
                r_ar_ok  <= w_ar_ok;
                r_ar_idx <= w_ar_off[AW+2:3];
                r_cnt    <= 4'(READ_LATENCY - 1);
                ARREADY  <= 1'b0;
                r_rst    <= R_WAIT;
            end else ARREADY <= 1'b1;
        end else if (r_rst == R_WAIT) begin
            if (r_cnt == 4'd0) begin
                RDATA  <= r_ar_ok ? r_mem[r_ar_idx] : 64'h0;
                r_rerr <= r_rerr | !r_ar_ok;
                RVALID <= 1'b1;
                r_rst  <= R_DATA;
            end else r_cnt <= r_cnt - 4'd1;
        end else if (RREADY) begin
            RVALID  <= 1'b0;
            RDATA   <= '0;
            ARREADY <= 1'b1;
            r_rst   <= R_IDLE;
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed checks of axi_slave_mem at READ_LATENCY 1 and 4.
// Both instances share inputs; inputs change and outputs are sampled on negedge.
module tb_axi_slave_mem;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] AWADDR = '0, ARADDR = '0;
    logic [63:0] WDATA = '0;
    logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic        awr1, wr1, bv1, arr1, rv1, ae1, awr4, wr4, bv4, arr4, rv4, ae4;
    logic [63:0] rd1, rd4;
    int          n_chk = 0, n_fail = 0;
    localparam logic [63:0] D1 = 64'hA5A5_0000_1234_5678;
    localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;

    always #5 clk = ~clk;

    axi_slave_mem #(.READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(awr1),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(wr1), .BVALID(bv1), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(arr1), .RDATA(rd1), .RVALID(rv1),
        .RREADY(RREADY), .addr_err(ae1));
    axi_slave_mem #(.READ_LATENCY(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(awr4),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(wr4), .BVALID(bv4), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(arr4), .RDATA(rd4), .RVALID(rv4),
        .RREADY(RREADY), .addr_err(ae4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d);
        logic seen = 1'b0;
        AWADDR = a; WDATA = d; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = bv1;
        end
        chk("wr_bvalid_seen", {63'd0, seen}, 64'd1);
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [63:0] exp);
        logic s1 = 1'b0, s4 = 1'b0;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        @(negedge clk);
        ARVALID = 1'b0;
        for (int k = 0; k < 20 && !(s1 && s4); k++) begin
            @(negedge clk);
            if (rv1 && !s1) begin s1 = 1'b1; chk({tag, "_l1"}, rd1, exp); end
            if (rv4 && !s4) begin s4 = 1'b1; chk({tag, "_l4"}, rd4, exp); end
        end
        chk({tag, "_done"}, {62'd0, s1, s4}, 64'd3);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_readys", {awr1, wr1, arr1, awr4, wr4, arr4}, 64'd0);
        chk("rst_valids", {bv1, rv1, bv4, rv4, ae1, ae4}, 64'd0);
        chk("rst_rdata", rd1 | rd4, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_readys", {awr1, wr1, arr1, awr4, wr4, arr4}, 64'h3F);
        chk("post_rst_valids", {bv1, rv1, bv4, rv4}, 64'd0);

        // same-cycle AW+W, BREADY high
        AWADDR = 32'h10; WDATA = D1; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("w1_after_hs", {bv1, awr1, wr1}, 64'd0);
        @(negedge clk);
        chk("w1_bvalid_up", {bv1, awr1, wr1}, 64'b100);
        @(negedge clk);
        chk("w1_bvalid_down", {bv1, awr1, wr1}, 64'b011);

        ARADDR = 32'h10; ARVALID = 1'b1; RREADY = 1'b1;
        @(negedge clk);
        ARVALID = 1'b0;
        chk("r1_after_hs", {rv1, arr1}, 64'd0);
        @(negedge clk);
        chk("r1_rvalid", {63'd0, rv1}, 64'd1);
        chk("r1_rdata", rd1, D1);
        @(negedge clk);
        chk("r1_done", {rv1, arr1}, 64'b01);
        chk("r1_rdata_clr", rd1, 64'd0);
        repeat (4) @(negedge clk);
        chk("r1_l4_done", {rv4, arr4}, 64'b01);

        // AW first, W three cycles later, BREADY low for 4 cycles
        AWADDR = 32'h18; AWVALID = 1'b1; BREADY = 1'b0;
        @(negedge clk);
        AWVALID = 1'b0;
        chk("w2_aw_held_a", {awr1, wr1}, 64'b01);
        @(negedge clk);
        chk("w2_aw_held_b", {awr1, wr1}, 64'b01);
        @(negedge clk);
        WDATA = D2; WVALID = 1'b1;
        @(negedge clk);
        WDATA = 64'hBAD0_BAD0_BAD0_BAD0;
        chk("w2_w_hs", {awr1, wr1, bv1}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("w2_bvalid_hold", {bv1, awr1, wr1}, 64'b100);
        end
        BREADY = 1'b1; WVALID = 1'b0;
        @(negedge clk);
        chk("w2_bvalid_done", {bv1, awr1, wr1}, 64'b011);
        rd("w2_readback", 32'h18, D2);

        // READ_LATENCY 4 with RREADY low two cycles after RVALID
        ARADDR = 32'h10; ARVALID = 1'b1; RREADY = 1'b0;
        @(negedge clk);
        ARVALID = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("r4_wait", {rv4, arr4}, 64'd0);
        end
        @(negedge clk);
        chk("r4_rvalid", {rv4, arr4}, 64'b10);
        chk("r4_rdata", rd4, D1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("r4_stall", {rv4, arr4}, 64'b10);
            chk("r4_stall_data", rd4, D1);
        end
        RREADY = 1'b1;
        @(negedge clk);
        chk("r4_done", {rv4, arr4, rv1, arr1}, 64'b0101);

        // collision: write commit and L1 read sample on the same edge
        wr(32'h28, 64'h1);
        AWADDR = 32'h28; WDATA = 64'h2; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        ARADDR = 32'h28; ARVALID = 1'b1; RREADY = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        @(negedge clk);
        chk("col_bvalid", {bv1, rv1}, 64'b11);
        chk("col_old_data", rd1, 64'h1);
        repeat (3) @(negedge clk);
        chk("col_l4_new_data", {rv4, rd4}, {1'b1, 64'h2});
        repeat (2) @(negedge clk);
        rd("col_next", 32'h28, 64'h2);

        // out-of-range write and read
        chk("oor_err_before", {ae1, ae4}, 64'd0);
        wr(32'h800, 64'hDEAD_BEEF);
        chk("oor_w_err", {ae1, ae4}, 64'b11);
        rd("oor_read", 32'h800, 64'h0);
        rd("oor_no_alias", 32'h0, 64'h0);

        // reset with BVALID pending
        AWADDR = 32'h18; WDATA = D1; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        @(negedge clk);
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge clk);
        chk("pend_bvalid", {63'd0, bv1}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {bv1, bv4, ae1, ae4, awr1, arr1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        BREADY = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_b_after_rst", {bv1, bv4}, 64'd0);
        rd("mem_cleared", 32'h18, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
